// File: rtl/uart_arb_pkg.sv
// Shared types and default parameters for the UART TX arbiter and its round-robin picker.
package uart_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ     = 3;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_TIMEOUT_CYC = 4096;

  // Index width for a vector of n entries, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set bit of 'valid' searching rr_ptr+1, rr_ptr+2, ...
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  int                   shamt;
  int                   off;
  int                   sum;

  // Rotate so the slot after rr_ptr lands at bit 0, then take the lowest set bit.
  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    shamt = int'(rr_ptr) + 1;
    dbl   = {valid, valid};
    rot   = NUM_REQ'(dbl >> shamt);
    off   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    sum = shamt + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    found = |valid;
    idx   = IDX_W'(sum);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART TX FIFO enqueue port between NUM_REQ byte streams, granting per message
// (round-robin), with an idle watchdog that force-releases a stalled owner.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ     = DEF_NUM_REQ,
  parameter  int DATA_W      = DEF_DATA_W,
  parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int IDX_W       = idx_w(NUM_REQ),
  localparam int CNT_W       = $clog2(TIMEOUT_CYC)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      arb_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_valid,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      timeout_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic               timeout_q, timeout_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               owner_valid;
  logic               owner_last;
  logic [DATA_W-1:0]  owner_data;
  logic               xfer;

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid  (req_valid),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  assign owner_valid = req_valid[grant_q];
  assign owner_last  = req_last[grant_q];
  assign owner_data  = req_data[grant_q*DATA_W +: DATA_W];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    idle_cnt_d = idle_cnt_q;
    timeout_d  = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    req_ready  = '0;
    xfer       = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (arb_en && pick_found) begin
          state_d    = ARB_LOCK;
          grant_d    = pick_idx;
          idle_cnt_d = '0;
        end
      end
      ARB_LOCK: begin
        tx_valid           = owner_valid;
        tx_data            = owner_data;
        req_ready[grant_q] = tx_ready;
        xfer               = owner_valid && tx_ready;
        // A last-byte transfer takes precedence over the watchdog on the same cycle.
        if (xfer && owner_last) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = grant_q;
        end else if (xfer) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == CNT_LAST) begin
          state_d   = ARB_IDLE;
          rr_ptr_d  = grant_q;
          timeout_d = 1'b1;
        end else if (!owner_valid && tx_ready) begin
          // A full FIFO is not the owner's fault, so the count only moves while it has room.
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= PTR_RESET;
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign busy          = (state_q == ARB_LOCK);
  assign grant_id      = grant_q;
  assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised and directed bench for uart_tx_arbiter against a message-level reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int T  = 16;

  logic            clock;
  logic            reset_n;
  logic            arb_en;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            tx_valid;
  logic [DW-1:0]   tx_data;
  logic            tx_ready;
  logic            busy;
  logic [1:0]      grant_id;
  logic            timeout_pulse;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(T)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .arb_en        (arb_en),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .grant_id      (grant_id),
    .timeout_pulse (timeout_pulse)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: owner (-1 = nobody), last finished owner, idle run length, pulse due.
  int m_owner, m_last, m_idle, m_gid;
  bit m_pulse;

  // Requester sources: per-requester byte queues with message-end flags.
  logic [7:0] q_data [N][$];
  bit         q_last [N][$];
  int         silent [N];

  // Observed transfers on the TX side.
  int         log_id  [$];
  logic [7:0] log_dat [$];
  int         log_cyc [$];
  int         pulses, pulse_cyc, cyc;

  bit gap_mode, rand_ready, rand_arb;

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_idle = 0; m_gid = 0; m_pulse = 0;
  endtask

  task automatic clear_log();
    log_id.delete(); log_dat.delete(); log_cyc.delete();
    pulses = 0; pulse_cyc = -1;
  endtask

  task automatic push_byte(input int i, input logic [7:0] d, input bit l);
    q_data[i].push_back(d);
    q_last[i].push_back(l);
  endtask

  task automatic push_rand_msg(input int i);
    int len;
    len = $urandom_range(1, 4);
    for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), b == len - 1);
  endtask

  // One clock cycle: drive at the falling edge, check mid-cycle, advance the model.
  task automatic step();
    logic [N-1:0] e_ready;
    bit           e_txv, done;
    for (int i = 0; i < N; i++) begin
      if (silent[i] > 0) silent[i]--;
      if (q_data[i].size() > 0 && silent[i] == 0 && (!gap_mode || $urandom_range(3) != 0)) begin
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = q_data[i][0];
        req_last[i]           = q_last[i][0];
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*DW +: DW]  = 8'($urandom);
        req_last[i]           = 1'($urandom);
      end
    end
    if (rand_ready) tx_ready = ($urandom_range(3) != 0);
    if (rand_arb)   arb_en   = ($urandom_range(7) != 0);
    #1;
    e_ready = '0;
    e_txv   = 1'b0;
    if (m_owner >= 0) begin
      e_ready[m_owner] = tx_ready;
      e_txv            = req_valid[m_owner];
    end
    check("busy", busy, m_owner >= 0);
    check("tx_valid", tx_valid, e_txv);
    check("req_ready", req_ready, e_ready);
    check("grant_id", grant_id, m_gid);
    check("timeout_pulse", timeout_pulse, m_pulse);
    if (e_txv) check("tx_data", tx_data, req_data[m_owner*DW +: DW]);
    if (tx_valid && tx_ready) begin
      log_id.push_back(int'(grant_id));
      log_dat.push_back(tx_data);
      log_cyc.push_back(cyc);
    end
    if (timeout_pulse) begin
      pulses++;
      pulse_cyc = cyc;
    end
    m_pulse = 0;
    if (m_owner < 0) begin
      if (arb_en && req_valid != '0) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (req_valid[c]) begin
            m_owner = c; m_gid = c; m_idle = 0;
            break;
          end
        end
      end
    end else begin
      done = req_valid[m_owner] && tx_ready;
      if (done) begin
        void'(q_data[m_owner].pop_front());
        void'(q_last[m_owner].pop_front());
        if (req_last[m_owner]) begin
          m_last = m_owner; m_owner = -1;
        end else begin
          m_idle = 0;
        end
      end else if (m_idle == T - 1) begin
        m_last = m_owner; m_owner = -1; m_pulse = 1;
      end else if (!req_valid[m_owner] && tx_ready) begin
        m_idle++;
      end
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      q_data[i].delete(); q_last[i].delete(); silent[i] = 0;
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    model_reset();
    clear_queues();
    #1;
    check("rst_busy", busy, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_timeout", timeout_pulse, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int start, c5;
    reset_n = 1'b0; arb_en = 1'b1; tx_ready = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    gap_mode = 0; rand_ready = 0; rand_arb = 0; cyc = 0;
    model_reset();
    clear_queues();
    clear_log();
    @(negedge clock);
    do_reset();

    // Single requester, three-byte message.
    clear_log();
    push_byte(0, 8'h55, 0); push_byte(0, 8'hAA, 0); push_byte(0, 8'h33, 1);
    start = cyc;
    run(6);
    check("t1_count", log_id.size(), 3);
    if (log_id.size() == 3) begin
      check("t1_b0", log_dat[0], 8'h55);
      check("t1_b1", log_dat[1], 8'hAA);
      check("t1_b2", log_dat[2], 8'h33);
      check("t1_first_cyc", log_cyc[0], start + 1);
      check("t1_last_cyc", log_cyc[2], start + 3);
    end
    check("t1_busy_after", busy, 0);

    // Three competing requesters from reset: grant order 0,1,2,0 with one bubble.
    do_reset();
    clear_log();
    push_byte(0, 8'h01, 0); push_byte(0, 8'h02, 1);
    push_byte(0, 8'h07, 0); push_byte(0, 8'h08, 1);
    push_byte(1, 8'h03, 0); push_byte(1, 8'h04, 1);
    push_byte(2, 8'h05, 0); push_byte(2, 8'h06, 1);
    start = cyc;
    run(16);
    check("t2_count", log_id.size(), 8);
    if (log_id.size() == 8) begin
      for (int m = 0; m < 4; m++) begin
        int id_exp;
        id_exp = (m == 3) ? 0 : m;
        check($sformatf("t2_id%0d", m), log_id[2*m], id_exp);
        check($sformatf("t2_id%0d_b", m), log_id[2*m+1], id_exp);
        check($sformatf("t2_cyc%0d", m), log_cyc[2*m], start + 1 + 3*m);
        check($sformatf("t2_cyc%0d_b", m), log_cyc[2*m+1], start + 2 + 3*m);
      end
      check("t2_dat6", log_dat[6], 8'h07);
      check("t2_dat7", log_dat[7], 8'h08);
    end

    // Long backpressure never trips the watchdog.
    clear_log();
    tx_ready = 1'b0;
    push_byte(1, 8'hC3, 1);
    run(10000);
    check("t3_no_pulse", pulses, 0);
    check("t3_busy", busy, 1);
    check("t3_grant", grant_id, 1);
    check("t3_no_xfer", log_id.size(), 0);
    tx_ready = 1'b1;
    run(3);
    check("t3_count", log_id.size(), 1);
    if (log_id.size() == 1) begin
      check("t3_id", log_id[0], 1);
      check("t3_dat", log_dat[0], 8'hC3);
    end

    // Owner stalls mid-message: forced release after T idle cycles, waiting req0 next.
    clear_log();
    push_byte(2, 8'h77, 0);
    start = cyc;
    step();
    push_byte(0, 8'h90, 1);
    for (int k = 0; k < 40 && log_id.size() < 2; k++) step();
    check("t4_pulses", pulses, 1);
    check("t4_pulse_cyc", pulse_cyc, start + 18);
    check("t4_count", log_id.size(), 2);
    if (log_id.size() == 2) begin
      check("t4_first_id", log_id[0], 2);
      check("t4_next_id", log_id[1], 0);
      check("t4_next_cyc", log_cyc[1], start + 19);
    end

    // arb_en low mid-message: message completes, no new grant until re-enabled.
    run(2);
    clear_log();
    push_byte(0, 8'hD0, 0); push_byte(0, 8'hD1, 0); push_byte(0, 8'hD2, 1);
    run(2);
    arb_en = 1'b0;
    push_byte(1, 8'hB1, 1);
    run(10);
    check("t5_count", log_id.size(), 3);
    check("t5_busy", busy, 0);
    arb_en = 1'b1;
    c5 = cyc;
    run(4);
    check("t5_count2", log_id.size(), 4);
    if (log_id.size() == 4) begin
      check("t5_id", log_id[3], 1);
      check("t5_cyc", log_cyc[3], c5 + 1);
    end

    // Asynchronous reset mid-message, then a 0/1 tie resolves to requester 0.
    clear_log();
    push_byte(0, 8'hE0, 0); push_byte(0, 8'hE1, 0); push_byte(0, 8'hE2, 0); push_byte(0, 8'hE3, 1);
    run(3);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_tx_valid", tx_valid, 0);
    check("t6_req_ready", req_ready, 0);
    check("t6_busy", busy, 0);
    @(negedge clock);
    do_reset();
    clear_log();
    push_byte(0, 8'hF0, 1);
    push_byte(1, 8'hF1, 1);
    start = cyc;
    run(6);
    check("t6_count", log_id.size(), 2);
    if (log_id.size() == 2) begin
      check("t6_first_id", log_id[0], 0);
      check("t6_first_cyc", log_cyc[0], start + 1);
      check("t6_second_id", log_id[1], 1);
    end

    // Random traffic with gaps, stalls, backpressure and arb_en toggling.
    gap_mode = 1; rand_ready = 1; rand_arb = 1;
    for (int k = 0; k < 6000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (q_data[i].size() < 3 && $urandom_range(7) == 0) push_rand_msg(i);
        if ($urandom_range(199) == 0) silent[i] = $urandom_range(10, 25);
      end
      step();
    end
    gap_mode = 0; rand_ready = 0; rand_arb = 0;
    tx_ready = 1'b1; arb_en = 1'b1;
    run(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
